llc_flush_sequencer: RTL and testbench

Controller that sequences whole-cache flush and reset walks for the LLC pipeline. On one accepted command it issues every set index, 0 to SETS-1, to the LLC pipeline over a valid/ready port. It bounds the number of in-flight set operations and counts per-set completions. It returns a single done token once every set has retired. It sits between the input decoder's flush/reset path and the pipeline, replacing an ad-hoc stalled-set counter.

---
 rtl/llc_flush_sequencer_pkg.sv | 22 ++
 rtl/llc_flush_credit_cnt.sv | 45 ++++
 rtl/llc_flush_sequencer_chk.sv | 19 +
 rtl/llc_flush_sequencer.sv | 133 +++++++++++++
 tb/tb_llc_flush_sequencer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/llc_flush_sequencer_pkg.sv
// Shared types and constants for the LLC flush/reset walk sequencer.
//   llc_flush_state_t         : walk controller states
//   LLC_SETS                  : default number of LLC sets
//   LLC_FLUSH_MAX_OUTSTANDING : default in-flight set operation limit
//   llc_flush_out_width()     : width needed to hold 0..max_val
package llc_flush_sequencer_pkg;

  typedef enum logic [1:0] {
    LLC_FLUSH_IDLE  = 2'd0,
    LLC_FLUSH_ISSUE = 2'd1,
    LLC_FLUSH_DRAIN = 2'd2,
    LLC_FLUSH_DONE  = 2'd3
  } llc_flush_state_t;

  localparam int unsigned LLC_SETS                  = 512;
  localparam int unsigned LLC_FLUSH_MAX_OUTSTANDING = 4;

  function automatic int llc_flush_out_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/llc_flush_credit_cnt.sv
// Up/down counter of issued-but-not-retired set operations.
//   clk, rst : clock, asynchronous active-low reset
//   clr_i    : synchronous clear (new walk)
//   inc_i    : one operation issued this cycle
//   dec_i    : one operation retired this cycle (caller guarantees count > 0
//              unless inc_i is also set)
//   cnt_o    : current outstanding count
//   limit_o  : count has reached MAX
module llc_flush_credit_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         limit_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);
  localparam logic [W-1:0] ONE_C = W'(1);

  logic [W-1:0] cnt_q;

  // Outstanding count; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {W{1'b0}};
    end else if (clr_i) begin
      cnt_q <= {W{1'b0}};
    end else if (inc_i && !dec_i) begin
      cnt_q <= cnt_q + ONE_C;
    end else if (dec_i && !inc_i) begin
      cnt_q <= cnt_q - ONE_C;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o   = cnt_q;
  assign limit_o = (cnt_q >= MAX_C);

endmodule

// File: rtl/llc_flush_sequencer_chk.sv
// Simulation checker for the flush sequencer's pipeline-side protocol.
//   clk, rst  : clock, asynchronous active-low reset
//   op_done_i : retire pulse from the pipeline
//   retire_i  : retire pulse as accepted by the sequencer
// A retire pulse that the sequencer had to drop means the pipeline retired
// something that was never issued.
module llc_flush_sequencer_chk (
  input logic clk,
  input logic rst,
  input logic op_done_i,
  input logic retire_i
);

  // Every op_done pulse must correspond to an issued operation.
  a_no_spurious_done: assert property (
    @(posedge clk) disable iff (!rst) op_done_i |-> retire_i
  );

endmodule

// File: rtl/llc_flush_sequencer.sv
// Sequences a whole-cache flush or reset walk: one accepted command issues
// set indices 0..SETS-1 to the LLC pipeline, bounded by MAX_OUTSTANDING
// in-flight operations, and returns one done token once all sets retired.
//   clk, rst              : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : walk command handshake, cmd_mode 0=flush 1=reset
//   op_valid/op_ready     : per-set operation handshake, op_set/op_mode payload
//   op_done               : one-cycle pulse, one issued set has retired
//   done_valid/done_ready : walk-complete token handshake
//   busy                  : any state other than IDLE
module llc_flush_sequencer
  import llc_flush_sequencer_pkg::*;
#(
  parameter int unsigned SETS            = LLC_SETS,
  parameter int unsigned MAX_OUTSTANDING = LLC_FLUSH_MAX_OUTSTANDING,
  parameter int unsigned SET_W           = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_mode,
  output logic             cmd_ready,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [SET_W-1:0] op_set,
  output logic             op_mode,
  input  logic             op_done,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int unsigned      CNT_W    = SET_W + 1;
  localparam int unsigned      OUT_W    = llc_flush_out_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_SET = CNT_W'(SETS - 1);
  localparam logic [CNT_W-1:0] ALL_SETS = CNT_W'(SETS);

  llc_flush_state_t state_q;
  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] retire_cnt_q;
  logic             mode_q;

  logic [CNT_W-1:0] retire_cnt_inc_s;
  logic [OUT_W-1:0] outstanding_s;
  logic             at_limit_s;
  logic             in_walk_s;
  logic             cmd_fire_s;
  logic             op_fire_s;
  logic             retire_s;

  assign in_walk_s  = (state_q == LLC_FLUSH_ISSUE) || (state_q == LLC_FLUSH_DRAIN);
  assign cmd_ready  = (state_q == LLC_FLUSH_IDLE);
  assign op_valid   = (state_q == LLC_FLUSH_ISSUE) && !at_limit_s;
  assign op_set     = issue_cnt_q[SET_W-1:0];
  assign op_mode    = mode_q;
  assign done_valid = (state_q == LLC_FLUSH_DONE);
  assign busy       = (state_q != LLC_FLUSH_IDLE);

  assign cmd_fire_s = cmd_ready && cmd_valid;
  assign op_fire_s  = op_valid && op_ready;
  // A retire is only honoured when something is in flight; an accept in the
  // same cycle counts, so an immediate echo on an empty pipe is legal.
  assign retire_s   = op_done && in_walk_s &&
                      ((outstanding_s != {OUT_W{1'b0}}) || op_fire_s);
  assign retire_cnt_inc_s = retire_s ? (retire_cnt_q + ONE_C) : retire_cnt_q;

  llc_flush_credit_cnt #(
    .MAX (MAX_OUTSTANDING),
    .W   (OUT_W)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cmd_fire_s),
    .inc_i   (op_fire_s),
    .dec_i   (retire_s),
    .cnt_o   (outstanding_s),
    .limit_o (at_limit_s)
  );

  llc_flush_sequencer_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .op_done_i (op_done),
    .retire_i  (retire_s)
  );

  // Walk controller: state, issue/retire counters and latched mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LLC_FLUSH_IDLE;
      issue_cnt_q  <= {CNT_W{1'b0}};
      retire_cnt_q <= {CNT_W{1'b0}};
      mode_q       <= 1'b0;
    end else begin
      case (state_q)
        LLC_FLUSH_IDLE: begin
          if (cmd_valid) begin
            mode_q       <= cmd_mode;
            issue_cnt_q  <= {CNT_W{1'b0}};
            retire_cnt_q <= {CNT_W{1'b0}};
            state_q      <= LLC_FLUSH_ISSUE;
          end
        end
        LLC_FLUSH_ISSUE: begin
          retire_cnt_q <= retire_cnt_inc_s;
          if (op_fire_s) begin
            issue_cnt_q <= issue_cnt_q + ONE_C;
            // Last set accepted: skip DRAIN if it also retired this cycle.
            if (issue_cnt_q == LAST_SET) begin
              state_q <= (retire_cnt_inc_s == ALL_SETS) ? LLC_FLUSH_DONE
                                                        : LLC_FLUSH_DRAIN;
            end
          end
        end
        LLC_FLUSH_DRAIN: begin
          retire_cnt_q <= retire_cnt_inc_s;
          if (retire_cnt_inc_s == ALL_SETS) begin
            state_q <= LLC_FLUSH_DONE;
          end
        end
        LLC_FLUSH_DONE: begin
          if (done_ready) begin
            state_q <= LLC_FLUSH_IDLE;
          end
        end
        default: begin
          state_q <= LLC_FLUSH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_flush_sequencer.sv
// Self-checking bench for llc_flush_sequencer (SETS = 8, MAX_OUTSTANDING = 2).
// A transaction-level model tracks whether a walk or done token is pending and
// how many sets have been issued and retired; expectations derive from it or
// from directed constants.
module tb_llc_flush_sequencer;

  localparam int SETS  = 8;
  localparam int MAX   = 2;
  localparam int SET_W = 3;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_mode;
  logic             cmd_ready;
  logic             op_valid;
  logic             op_ready;
  logic [SET_W-1:0] op_set;
  logic             op_mode;
  logic             op_done;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  bit m_walk;
  bit m_done;
  bit m_mode;
  int m_issued;
  int m_retired;

  llc_flush_sequencer #(
    .SETS            (SETS),
    .MAX_OUTSTANDING (MAX),
    .SET_W           (SET_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_mode   (cmd_mode),
    .cmd_ready  (cmd_ready),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_set     (op_set),
    .op_mode    (op_mode),
    .op_done    (op_done),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit e_cmd_ready();
    return !m_walk && !m_done;
  endfunction

  function automatic bit e_op_valid();
    return m_walk && (m_issued < SETS) && ((m_issued - m_retired) < MAX);
  endfunction

  // op_done may only be pulsed for something in flight (or accepted now)
  function automatic bit done_legal();
    return m_walk && (((m_issued - m_retired) > 0) || (e_op_valid() && op_ready));
  endfunction

  task automatic model_reset();
    m_walk = 0; m_done = 0; m_mode = 0; m_issued = 0; m_retired = 0;
  endtask

  task automatic drive_idle();
    cmd_valid = 0; cmd_mode = 0; op_ready = 0; op_done = 0; done_ready = 0;
  endtask

  // Advance one clock, updating the model with the inputs presented.
  task automatic tick();
    bit acc;
    acc = e_op_valid() && op_ready;
    @(posedge clk);
    if (e_cmd_ready()) begin
      if (cmd_valid) begin
        m_walk = 1; m_mode = cmd_mode; m_issued = 0; m_retired = 0;
      end
    end else if (m_walk) begin
      if (acc) m_issued++;
      if (op_done) m_retired++;
      if (m_retired == SETS) begin
        m_walk = 0; m_done = 1;
      end
    end else if (m_done && done_ready) begin
      m_done = 0;
    end
    #1;
  endtask

  task automatic start_walk(input bit mode);
    cmd_valid = 1; cmd_mode = mode;
    tick();
    cmd_valid = 0; cmd_mode = 0;
  endtask

  // Run the remaining walk with a fast pipeline and take the done token.
  task automatic finish_walk(output bit ok);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (m_done && done_valid) begin
        op_ready = 0; op_done = 0; done_ready = 1;
        tick();
        done_ready = 0;
        ok = 1;
        break;
      end
      op_ready = 1;
      op_done  = done_legal();
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 0;
    drive_idle();
    model_reset();
    #12;
    tests_run++;
    if ({cmd_ready, op_valid, op_set, op_mode, done_valid, busy} !== 8'b1_0_000_0_0_0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {cmd_ready, op_valid, op_set, op_mode, done_valid, busy}, 8'b1_0_000_0_0_0);
    end
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_fast_flush();
    bit ok;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fast_cmd_ready got=%b exp=1", cmd_ready);
    end
    start_walk(1'b0);
    for (int i = 0; i < SETS; i++) begin
      op_ready = 1; op_done = 1;
      tests_run++;
      if (op_valid !== 1'b1 || op_set !== SET_W'(i)) begin
        tests_failed++;
        $display("FAIL fast_issue[%0d] got valid=%b set=%0d exp valid=1 set=%0d",
                 i, op_valid, op_set, i);
      end
      tick();
    end
    drive_idle();
    tests_run++;
    if (done_valid !== 1'b1 || op_mode !== 1'b0 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fast_done got done=%b mode=%b cmd_ready=%b exp 1 0 0",
               done_valid, op_mode, cmd_ready);
    end
    done_ready = 1;
    tick();
    done_ready = 0;
    tests_run++;
    if (cmd_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fast_return_idle got cmd_ready=%b done=%b busy=%b exp 1 0 0",
               cmd_ready, done_valid, busy);
    end
    ok = 1;
  endtask

  task automatic test_credit_limit();
    bit ok;
    start_walk(1'b0);
    op_ready = 1; op_done = 0;
    for (int i = 0; i < MAX; i++) begin
      tests_run++;
      if (op_valid !== 1'b1 || op_set !== SET_W'(i)) begin
        tests_failed++;
        $display("FAIL credit_issue[%0d] got valid=%b set=%0d exp valid=1 set=%0d",
                 i, op_valid, op_set, i);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (op_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL credit_blocked[%0d] got valid=%b exp 0", i, op_valid);
      end
      tick();
    end
    op_done = 1;
    tick();
    op_done = 0;
    tests_run++;
    if (op_valid !== 1'b1 || op_set !== 3'd2) begin
      tests_failed++;
      $display("FAIL credit_reenable got valid=%b set=%0d exp valid=1 set=2", op_valid, op_set);
    end
    tick();
    tests_run++;
    if (op_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL credit_one_more got valid=%b exp 0", op_valid);
    end
    finish_walk(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL credit_walk_timeout got done=0 exp done=1");
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    start_walk(1'b0);
    for (int i = 0; i < 3; i++) begin
      op_ready = 1; op_done = 1;
      tick();
    end
    op_ready = 0; op_done = 0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (op_valid !== 1'b1 || op_set !== 3'd3) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] got valid=%b set=%0d exp valid=1 set=3", i, op_valid, op_set);
      end
      tick();
    end
    op_ready = 1; op_done = 1;
    tick();
    op_ready = 0; op_done = 0;
    tests_run++;
    if (op_valid !== 1'b1 || op_set !== 3'd4) begin
      tests_failed++;
      $display("FAIL bp_advance got valid=%b set=%0d exp valid=1 set=4", op_valid, op_set);
    end
    finish_walk(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL bp_walk_timeout got done=0 exp done=1");
    end
  endtask

  task automatic test_simul_at_max();
    bit ok;
    start_walk(1'b1);
    op_ready = 1; op_done = 0;
    tick();                       // set 0 in flight
    op_done = 1;
    tests_run++;
    if (op_valid !== 1'b1 || op_set !== 3'd1) begin
      tests_failed++;
      $display("FAIL simul_pre got valid=%b set=%0d exp valid=1 set=1", op_valid, op_set);
    end
    tick();                       // set 1 accepted while set 0 retires
    op_done = 0;
    tests_run++;
    if (op_valid !== 1'b1 || op_set !== 3'd2) begin
      tests_failed++;
      $display("FAIL simul_still_eligible got valid=%b set=%0d exp valid=1 set=2",
               op_valid, op_set);
    end
    tick();                       // set 2 accepted, two in flight
    tests_run++;
    if (op_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_reach_max got valid=%b exp 0", op_valid);
    end
    op_done = 1;
    tick();
    op_done = 1;
    tests_run++;
    if (op_valid !== 1'b1 || op_set !== 3'd3) begin
      tests_failed++;
      $display("FAIL simul_at_max_pre got valid=%b set=%0d exp valid=1 set=3", op_valid, op_set);
    end
    tick();                       // accept + retire with one slot used
    tests_run++;
    if (op_valid !== 1'b1 || op_set !== 3'd4) begin
      tests_failed++;
      $display("FAIL simul_at_max_post got valid=%b set=%0d exp valid=1 set=4", op_valid, op_set);
    end
    finish_walk(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL simul_walk_timeout got done=0 exp done=1");
    end
  endtask

  task automatic test_reset_mid_walk();
    bit ok;
    start_walk(1'b0);
    for (int i = 0; i < 5; i++) begin
      op_ready = 1; op_done = 1;
      tick();
    end
    op_ready = 0; op_done = 0;
    tests_run++;
    if (op_set !== 3'd5 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre got set=%0d busy=%b exp set=5 busy=1", op_set, busy);
    end
    #2 rst = 0;
    #1;
    model_reset();
    tests_run++;
    if ({cmd_ready, op_valid, op_set, op_mode, done_valid, busy} !== 8'b1_0_000_0_0_0) begin
      tests_failed++;
      $display("FAIL midrst_async got=%b exp=%b",
               {cmd_ready, op_valid, op_set, op_mode, done_valid, busy}, 8'b1_0_000_0_0_0);
    end
    @(negedge clk);
    rst = 1;
    tick();
    start_walk(1'b1);
    tests_run++;
    if (op_valid !== 1'b1 || op_set !== 3'd0 || op_mode !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_restart got valid=%b set=%0d mode=%b exp 1 0 1",
               op_valid, op_set, op_mode);
    end
    finish_walk(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL midrst_walk_timeout got done=0 exp done=1");
    end
  endtask

  task automatic test_done_handshake();
    bit ok;
    start_walk(1'b1);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (done_valid) begin
        ok = 1;
        break;
      end
      op_ready = 1;
      op_done  = done_legal();
      tick();
    end
    op_ready = 0; op_done = 0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL hs_reach_done_timeout got done=0 exp done=1");
    end
    cmd_valid = 1; cmd_mode = 0; done_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (done_valid !== 1'b1 || cmd_ready !== 1'b0 || op_mode !== 1'b1) begin
        tests_failed++;
        $display("FAIL hs_hold[%0d] got done=%b cmd_ready=%b mode=%b exp 1 0 1",
                 i, done_valid, cmd_ready, op_mode);
      end
      tick();
    end
    done_ready = 1;
    tick();
    done_ready = 0;
    tests_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_idle got cmd_ready=%b busy=%b done=%b exp 1 0 0",
               cmd_ready, busy, done_valid);
    end
    tick();
    cmd_valid = 0;
    tests_run++;
    if (op_valid !== 1'b1 || op_set !== 3'd0 || op_mode !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_new_cmd got valid=%b set=%0d mode=%b exp 1 0 0",
               op_valid, op_set, op_mode);
    end
    finish_walk(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL hs_walk_timeout got done=0 exp done=1");
    end
  endtask

  task automatic test_random();
    int walks;
    walks = 0;
    for (int c = 0; c < 2500 && walks < 8; c++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_mode   = $urandom_range(0, 1) == 1;
      op_ready   = ($urandom_range(0, 9) < 7);
      op_done    = done_legal() && ($urandom_range(0, 1) == 1);
      done_ready = ($urandom_range(0, 2) == 0);
      tests_run++;
      if (cmd_ready !== e_cmd_ready() || op_valid !== e_op_valid() ||
          done_valid !== m_done || busy !== (m_walk || m_done) || op_mode !== m_mode) begin
        tests_failed++;
        $display("FAIL rand_ctrl cyc=%0d got rdy=%b v=%b dn=%b bsy=%b md=%b exp %b %b %b %b %b",
                 c, cmd_ready, op_valid, done_valid, busy, op_mode,
                 e_cmd_ready(), e_op_valid(), m_done, m_walk || m_done, m_mode);
      end
      if (e_op_valid()) begin
        tests_run++;
        if (op_set !== SET_W'(m_issued)) begin
          tests_failed++;
          $display("FAIL rand_set cyc=%0d got=%0d exp=%0d", c, op_set, m_issued);
        end
      end
      if (m_done && done_ready) walks++;
      tick();
    end
    drive_idle();
    tests_run++;
    if (walks < 8) begin
      tests_failed++;
      $display("FAIL rand_walks_timeout got=%0d exp=8", walks);
    end
  endtask

  initial begin
    test_reset();
    test_fast_flush();
    test_credit_limit();
    test_backpressure();
    test_simul_at_max();
    test_reset_mid_walk();
    test_done_handshake();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
